fetch_queue: RTL and testbench
==============================

// Module: fetch_queue
// PURPOSE
//   Instruction prefetch unit that replaces the bare PC + instruction memory front end of the 5-stage pipeline.
//   Issues word fetches to a variable-latency instruction memory over a req/ack handshake.
//   Buffers returned instructions with their PC+4 in a DEPTH-entry FIFO and feeds the Fetch/Decode buffer
//   over a valid/ready handshake.
//   Flushes and restarts on the branch redirect produced in the memory-access stage (pcSrc, branch address).
// PARAMETERS
//   DEPTH     4      FIFO entries, power of two, >= 2
//   RESET_PC  32'h0  first fetch address after reset
// PORTS
//   clk_i            in   1   clock; all state changes on its rising edge
//   rst_ni           in   1   asynchronous active-low reset
//   imemReq_o        out  1   fetch request; held high until imemAck_i
//   imemAddr_o       out  32  fetch address; stable while imemReq_o=1
//   imemAck_i        in   1   memory returns data this cycle; valid only while imemReq_o=1
//   imemData_i       in   32  instruction word, valid with imemAck_i
//   redirect_i       in   1   taken branch (pcSrc): flush queue, restart at redirectAddr_i
//   redirectAddr_i   in   32  branch target address
//   valid_o          out  1   head entry available to decode
//   ready_i          in   1   decode accepts head entry (stall when 0)
//   instr_o          out  32  head instruction word
//   nextInstrAddr_o  out  32  head PC + 4
//   count_o          out  $clog2(DEPTH)+1  occupied entries
// BEHAVIOUR
//   Reset (async, rst_ni=0)
//     state=IDLE; fetchPc=RESET_PC; FIFO empty.
//     imemReq_o=0, imemAddr_o=RESET_PC, valid_o=0, count_o=0, instr_o=0, nextInstrAddr_o=0.
//     Reset mid-request abandons it; the memory must tolerate req dropping.
//   Registered outputs: imemReq_o, imemAddr_o. valid_o = (count_o!=0); instr_o/nextInstrAddr_o = head entry, 0 when empty.
//   Credit rule: a fetch is issued only if count + 1 (the issued fetch) <= DEPTH,
//     using count after this cycle's dequeue; at most one outstanding fetch.
//   FSM:
//     IDLE
//       credit -> FETCH; req=1; addr=fetchPc.
//     FETCH, ack=1, no redirect
//       enqueue {data, fetchPc+4}; fetchPc+=4.
//       credit remains -> stay FETCH with addr+4 (back-to-back, 1 instr/cycle at 1-cycle latency);
//       otherwise -> IDLE with req=0.
//     FETCH, redirect=1, ack=0
//       -> DROP; req stays high, addr unchanged.
//     FETCH, redirect=1, ack=1
//       data discarded; -> IDLE.
//     DROP
//       on ack: discard data -> FETCH with addr=fetchPc.
//       redirect during DROP only updates fetchPc (last redirect wins).
//   Redirect (any state)
//     FIFO flushed at that edge (count_o=0 next cycle); fetchPc <= redirectAddr_i.
//     Redirect beats a same-cycle dequeue and a same-cycle enqueue.
//   FIFO
//     Pointers wrap modulo DEPTH.
//     Simultaneous enqueue+dequeue leaves count unchanged.
//     Enqueue when full is impossible under the credit rule; the implementation asserts on it in simulation.
//   Latency: ack edge -> valid_o 1 cycle later.
//   Address arithmetic: fetchPc+4 wraps at 2^32, no error.
// CONFIGURATION
//   FETCH_BYPASS_EN defined
//     FIFO empty, ack=1, ready_i=1, no redirect: imemData_i/fetchPc+4 drive the outputs combinationally,
//     valid_o=1 that cycle, nothing is enqueued; 0-cycle ack->decode latency.
//     The credit check treats the bypassed word as consumed.
//   FETCH_BYPASS_EN undefined
//     Every instruction passes through the FIFO; 1-cycle latency; no memory-to-decode combinational path.
// TESTING
//   Reset release, ack 1 cycle after each req, ready_i=1
//     -> addrs 0,4,8,... back-to-back;
//     -> valid_o from cycle 3, nextInstrAddr_o 4,8,12.
//   ready_i=0 for 10 cycles, DEPTH=4
//     -> count_o saturates at 4; imemReq_o=0 while no credit;
//     -> on ready_i=1 the order is preserved: instr at 0,4,8,12.
//   Ack held off 5 cycles
//     -> imemAddr_o stays 0x10 and req stays 1 throughout; one enqueue on ack.
//   redirect_i=1, addr 0x40, while 3 entries queued and a fetch is outstanding
//     -> count_o=0 next cycle; stale ack discarded; next req addr=0x40.
//   redirect_i with ack in the same cycle, then a second redirect to 0x80 during DROP
//     -> neither word is enqueued; next fetch at 0x80.
//   rst_ni=0 asserted mid-FETCH, asynchronously
//     -> imemReq_o=0 and valid_o=0 immediately;
//     -> fetch restarts at RESET_PC.
//     With FETCH_BYPASS_EN: empty queue, ack=1, ready_i=1 -> valid_o=1 in the ack cycle.

Source files
------------

// File: rtl/fetch_queue.sv
// Instruction prefetch queue: req/ack fetch engine feeding decode through a FIFO.
// Define FETCH_BYPASS_EN to pass a returning word straight to decode when the queue is empty.
module fetch_queue #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   output logic                       imemReq_o,
   output logic [31:0]                imemAddr_o,
   input  logic                       imemAck_i,
   input  logic [31:0]                imemData_i,
   input  logic                       redirect_i,
   input  logic [31:0]                redirectAddr_i,
   output logic                       valid_o,
   input  logic                       ready_i,
   output logic [31:0]                instr_o,
   output logic [31:0]                nextInstrAddr_o,
   output logic [$clog2(DEPTH):0]     count_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      DROP
   } state_e;

   state_e        state_q, state_d;
   logic [31:0]   pc_q, pc_d;
   logic          req_q, req_d;
   logic [31:0]   addr_q, addr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [AW-1:0] wr_q, wr_d;
   logic [AW-1:0] rd_q, rd_d;

   logic [31:0]   instr_mem_q [DEPTH];
   logic [31:0]   nia_mem_q   [DEPTH];

   logic          ack;
   logic          empty;
   logic          bypass;
   logic          enq;
   logic          deq;
   logic          credit;
   logic [31:0]   pc_inc;

   assign ack    = imemAck_i & req_q;
   assign empty  = (cnt_q == '0);
   assign pc_inc = pc_q + 32'd4;

`ifdef FETCH_BYPASS_EN
   assign bypass = empty & ack & ready_i & ~redirect_i
                 & (state_q == FETCH);
`else
   assign bypass = 1'b0;
`endif

   assign deq = ~empty & ready_i;
   assign enq = (state_q == FETCH) & ack & ~redirect_i & ~bypass;

   always_comb begin
      cnt_d = cnt_q - CW'(deq) + CW'(enq);
      wr_d  = enq ? wr_q + AW'(1) : wr_q;
      rd_d  = deq ? rd_q + AW'(1) : rd_q;
      // A flush wins over any same-cycle enqueue or dequeue.
      if (redirect_i) begin
         cnt_d = '0;
         wr_d  = '0;
         rd_d  = '0;
      end
   end

   assign credit = (cnt_d < CW'(DEPTH));

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      req_d   = req_q;
      addr_d  = addr_q;
      unique case (state_q)
         IDLE: begin
            if (redirect_i) pc_d = redirectAddr_i;
            if (credit) begin
               state_d = FETCH;
               req_d   = 1'b1;
               addr_d  = pc_d;
            end
         end
         FETCH: begin
            if (redirect_i) begin
               pc_d = redirectAddr_i;
               if (ack) begin
                  state_d = IDLE;
                  req_d   = 1'b0;
               end else begin
                  state_d = DROP;
               end
            end else if (ack) begin
               pc_d = pc_inc;
               if (credit) begin
                  addr_d = pc_inc;
               end else begin
                  state_d = IDLE;
                  req_d   = 1'b0;
               end
            end
         end
         DROP: begin
            if (redirect_i) pc_d = redirectAddr_i;
            // The stale word is thrown away; restart at the latest target.
            if (ack) begin
               state_d = FETCH;
               addr_d  = pc_d;
            end
         end
         default: begin
            state_d = IDLE;
            req_d   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         pc_q    <= RESET_PC;
         req_q   <= 1'b0;
         addr_q  <= RESET_PC;
         cnt_q   <= '0;
         wr_q    <= '0;
         rd_q    <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         req_q   <= req_d;
         addr_q  <= addr_d;
         cnt_q   <= cnt_d;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (enq) begin
         instr_mem_q[wr_q] <= imemData_i;
         nia_mem_q[wr_q]   <= pc_inc;
      end
   end

   always_comb begin
      valid_o         = ~empty;
      instr_o         = empty ? 32'h0 : instr_mem_q[rd_q];
      nextInstrAddr_o = empty ? 32'h0 : nia_mem_q[rd_q];
      if (bypass) begin
         valid_o         = 1'b1;
         instr_o         = imemData_i;
         nextInstrAddr_o = pc_inc;
      end
   end

   assign imemReq_o  = req_q;
   assign imemAddr_o = addr_q;
   assign count_o    = cnt_q;

`ifndef SYNTHESIS
   a_no_full_enq : assert property (
      @(posedge clk_i) disable iff (!rst_ni)
      !(enq && cnt_q == CW'(DEPTH))
   );
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: a memory model pushes expected words
// on ack, a monitor pops and compares them as decode accepts.
`timescale 1ns/1ps
module tb_fetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        imemReq_o;
  logic [31:0] imemAddr_o;
  logic        imemAck_i;
  logic [31:0] imemData_i;
  logic        redirect_i = 1'b0;
  logic [31:0] redirectAddr_i = 32'h0;
  logic        valid_o;
  logic        ready_i = 1'b0;
  logic [31:0] instr_o;
  logic [31:0] nextInstrAddr_o;
  logic [2:0]  count_o;

  always #5 clk = ~clk;

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk_i(clk),
    .rst_ni(rst_ni),
    .imemReq_o(imemReq_o),
    .imemAddr_o(imemAddr_o),
    .imemAck_i(imemAck_i),
    .imemData_i(imemData_i),
    .redirect_i(redirect_i),
    .redirectAddr_i(redirectAddr_i),
    .valid_o(valid_o),
    .ready_i(ready_i),
    .instr_o(instr_o),
    .nextInstrAddr_o(nextInstrAddr_o),
    .count_o(count_o)
  );

  int total = 0;
  int bad = 0;
  int pops = 0;

  logic [63:0] exp_q[$];
  logic [63:0] sb_e;
  logic [31:0] exp_pc = RESET_PC;

  logic        mem_en = 1'b0;
  logic        auto_ack = 1'b0;
  logic [31:0] auto_data = 32'h0;
  logic        man_ack = 1'b0;
  logic [31:0] man_data = 32'h0;
  int          mem_lat = 0;
  int          wcnt = 0;

  assign imemAck_i  = mem_en ? auto_ack : man_ack;
  assign imemData_i = mem_en ? auto_data : man_data;

  function automatic logic [31:0] mkword(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h0000_0013;
  endfunction

  always @(negedge clk) begin
    if (mem_en && rst_ni && imemReq_o) begin
      if (wcnt >= mem_lat) begin
        total++;
        if (imemAddr_o !== exp_pc) begin
          bad++;
          $display("FAIL fetch_addr got=%h want=%h",
                   imemAddr_o, exp_pc);
        end
        auto_ack  = 1'b1;
        auto_data = mkword(imemAddr_o);
        exp_q.push_back({mkword(exp_pc), exp_pc + 32'd4});
        exp_pc = exp_pc + 32'd4;
        wcnt = 0;
      end else begin
        auto_ack = 1'b0;
        wcnt++;
      end
    end else begin
      auto_ack = 1'b0;
      wcnt = 0;
    end
    #1;
    if (rst_ni) begin
      total++;
      if (count_o > DEPTH) begin
        bad++;
        $display("FAIL count_bound got=%0d want<=%0d", count_o, DEPTH);
      end
      if (!valid_o) begin
        total++;
        if (instr_o !== 32'h0 || nextInstrAddr_o !== 32'h0) begin
          bad++;
          $display("FAIL empty_zero instr=%h nia=%h want 0",
                   instr_o, nextInstrAddr_o);
        end
      end else if (ready_i) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_out instr=%h nia=%h want none",
                   instr_o, nextInstrAddr_o);
        end else begin
          sb_e = exp_q.pop_front();
          pops++;
          if (instr_o !== sb_e[63:32] ||
              nextInstrAddr_o !== sb_e[31:0]) begin
            bad++;
            $display("FAIL out_word got=%h/%h want=%h/%h",
                     instr_o, nextInstrAddr_o,
                     sb_e[63:32], sb_e[31:0]);
          end
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    mem_en = 1'b0;
    man_ack = 1'b0;
    redirect_i = 1'b0;
    mem_lat = 0;
    cyc(2);
    exp_q.delete();
    exp_pc = RESET_PC;
    rst_ni = 1'b1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    ready_i = 1'b1;
    cyc(2);
    total++;
    if (imemReq_o !== 1'b0) begin
      bad++; $display("FAIL rst_req got=%b want=0", imemReq_o);
    end
    total++;
    if (imemAddr_o !== RESET_PC) begin
      bad++; $display("FAIL rst_addr got=%h want=%h", imemAddr_o, RESET_PC);
    end
    total++;
    if (valid_o !== 1'b0 || count_o !== 3'd0) begin
      bad++;
      $display("FAIL rst_valid got=%b/%0d want=0/0", valid_o, count_o);
    end
    total++;
    if (instr_o !== 32'h0 || nextInstrAddr_o !== 32'h0) begin
      bad++;
      $display("FAIL rst_data got=%h/%h want=0/0",
               instr_o, nextInstrAddr_o);
    end
  endtask

  task automatic test_stream();
    int p0;
    do_reset();
    ready_i = 1'b1;
    mem_en = 1'b1;
    p0 = pops;
    cyc(1);
    total++;
    if (imemReq_o !== 1'b1 || imemAddr_o !== RESET_PC || valid_o !== 1'b0) begin
      bad++;
      $display("FAIL first_req got=%b/%h/%b want=1/%h/0",
               imemReq_o, imemAddr_o, valid_o, RESET_PC);
    end
    cyc(1);
    total++;
    if (valid_o !== 1'b1 || count_o !== 3'd1) begin
      bad++;
      $display("FAIL first_valid got=%b/%0d want=1/1", valid_o, count_o);
    end
    cyc(20);
    total++;
    if (pops - p0 < 18) begin
      bad++; $display("FAIL stream_rate got=%0d want>=18", pops - p0);
    end
  endtask

  task automatic test_stall();
    int p0;
    do_reset();
    ready_i = 1'b0;
    mem_en = 1'b1;
    cyc(10);
    total++;
    if (count_o !== 3'd4 || imemReq_o !== 1'b0 || valid_o !== 1'b1) begin
      bad++;
      $display("FAIL stall_full got=%0d/%b/%b want=4/0/1",
               count_o, imemReq_o, valid_o);
    end
    ready_i = 1'b1;
    p0 = pops;
    cyc(12);
    total++;
    if (pops - p0 < 8) begin
      bad++; $display("FAIL stall_drain got=%0d want>=8", pops - p0);
    end
  endtask

  task automatic test_ack_delay();
    int n;
    do_reset();
    ready_i = 1'b1;
    mem_en = 1'b1;
    n = 0;
    while (imemAddr_o !== 32'h10 && n < 20) begin
      cyc(1);
      n++;
    end
    total++;
    if (imemAddr_o !== 32'h10) begin
      bad++; $display("FAIL wait_0x10 got=%h want=00000010", imemAddr_o);
    end
    mem_lat = 5;
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      total++;
      if (imemReq_o !== 1'b1 || imemAddr_o !== 32'h10) begin
        bad++;
        $display("FAIL hold_req got=%b/%h want=1/00000010",
                 imemReq_o, imemAddr_o);
      end
    end
    mem_lat = 0;
    total++;
    if (count_o !== 3'd0) begin
      bad++; $display("FAIL hold_empty got=%0d want=0", count_o);
    end
    cyc(1);
    total++;
    if (count_o !== 3'd1) begin
      bad++; $display("FAIL ack_enq got=%0d want=1", count_o);
    end
    cyc(5);
  endtask

  task automatic test_redirect_flush();
    int n;
    int p0;
    do_reset();
    ready_i = 1'b0;
    mem_en = 1'b1;
    n = 0;
    while (count_o !== 3'd3 && n < 20) begin
      cyc(1);
      n++;
    end
    total++;
    if (count_o !== 3'd3 || imemReq_o !== 1'b1) begin
      bad++;
      $display("FAIL fill3 got=%0d/%b want=3/1", count_o, imemReq_o);
    end
    mem_en = 1'b0;
    redirect_i = 1'b1;
    redirectAddr_i = 32'h40;
    exp_q.delete();
    cyc(1);
    redirect_i = 1'b0;
    total++;
    if (count_o !== 3'd0 || valid_o !== 1'b0) begin
      bad++;
      $display("FAIL flush got=%0d/%b want=0/0", count_o, valid_o);
    end
    total++;
    if (imemReq_o !== 1'b1 || imemAddr_o !== 32'h0C) begin
      bad++;
      $display("FAIL drop_hold got=%b/%h want=1/0000000c",
               imemReq_o, imemAddr_o);
    end
    man_ack = 1'b1;
    man_data = 32'hBAD0_BAD0;
    cyc(1);
    man_ack = 1'b0;
    total++;
    if (imemReq_o !== 1'b1 || imemAddr_o !== 32'h40 || count_o !== 3'd0) begin
      bad++;
      $display("FAIL refetch got=%b/%h/%0d want=1/00000040/0",
               imemReq_o, imemAddr_o, count_o);
    end
    exp_pc = 32'h40;
    ready_i = 1'b1;
    mem_en = 1'b1;
    p0 = pops;
    cyc(10);
    total++;
    if (pops - p0 < 7) begin
      bad++; $display("FAIL flush_resume got=%0d want>=7", pops - p0);
    end
  endtask

  task automatic test_redirect_drop();
    int p0;
    do_reset();
    ready_i = 1'b1;
    cyc(1);
    total++;
    if (imemReq_o !== 1'b1 || imemAddr_o !== RESET_PC) begin
      bad++;
      $display("FAIL d_req0 got=%b/%h want=1/%h",
               imemReq_o, imemAddr_o, RESET_PC);
    end
    man_ack = 1'b1;
    man_data = 32'hDEAD_0001;
    redirect_i = 1'b1;
    redirectAddr_i = 32'h40;
    cyc(1);
    man_ack = 1'b0;
    redirect_i = 1'b0;
    total++;
    if (imemReq_o !== 1'b0 || count_o !== 3'd0) begin
      bad++;
      $display("FAIL ack_redir got=%b/%0d want=0/0", imemReq_o, count_o);
    end
    cyc(1);
    total++;
    if (imemReq_o !== 1'b1 || imemAddr_o !== 32'h40) begin
      bad++;
      $display("FAIL d_req40 got=%b/%h want=1/00000040",
               imemReq_o, imemAddr_o);
    end
    redirect_i = 1'b1;
    redirectAddr_i = 32'h60;
    cyc(1);
    redirectAddr_i = 32'h80;
    total++;
    if (imemReq_o !== 1'b1 || imemAddr_o !== 32'h40 || count_o !== 3'd0) begin
      bad++;
      $display("FAIL d_drop got=%b/%h/%0d want=1/00000040/0",
               imemReq_o, imemAddr_o, count_o);
    end
    cyc(1);
    redirect_i = 1'b0;
    total++;
    if (imemReq_o !== 1'b1 || imemAddr_o !== 32'h40) begin
      bad++;
      $display("FAIL d_drop2 got=%b/%h want=1/00000040",
               imemReq_o, imemAddr_o);
    end
    man_ack = 1'b1;
    man_data = 32'hDEAD_0002;
    cyc(1);
    man_ack = 1'b0;
    total++;
    if (imemReq_o !== 1'b1 || imemAddr_o !== 32'h80 ||
        count_o !== 3'd0 || valid_o !== 1'b0) begin
      bad++;
      $display("FAIL d_req80 got=%b/%h/%0d/%b want=1/00000080/0/0",
               imemReq_o, imemAddr_o, count_o, valid_o);
    end
    exp_pc = 32'h80;
    mem_en = 1'b1;
    p0 = pops;
    cyc(8);
    total++;
    if (pops - p0 < 5) begin
      bad++; $display("FAIL drop_resume got=%0d want>=5", pops - p0);
    end
  endtask

  task automatic test_wrap();
    int p0;
    do_reset();
    ready_i = 1'b1;
    redirect_i = 1'b1;
    redirectAddr_i = 32'hFFFF_FFF8;
    cyc(1);
    redirect_i = 1'b0;
    total++;
    if (imemReq_o !== 1'b1 || imemAddr_o !== 32'hFFFF_FFF8) begin
      bad++;
      $display("FAIL wrap_req got=%b/%h want=1/fffffff8",
               imemReq_o, imemAddr_o);
    end
    exp_pc = 32'hFFFF_FFF8;
    mem_en = 1'b1;
    p0 = pops;
    cyc(8);
    total++;
    if (pops - p0 < 5) begin
      bad++; $display("FAIL wrap_resume got=%0d want>=5", pops - p0);
    end
  endtask

  task automatic test_async_reset();
    int p0;
    do_reset();
    ready_i = 1'b1;
    mem_en = 1'b1;
    cyc(6);
    #2;
    rst_ni = 1'b0;
    exp_q.delete();
    #1;
    total++;
    if (imemReq_o !== 1'b0 || valid_o !== 1'b0 || count_o !== 3'd0) begin
      bad++;
      $display("FAIL async_rst got=%b/%b/%0d want=0/0/0",
               imemReq_o, valid_o, count_o);
    end
    cyc(2);
    exp_pc = RESET_PC;
    rst_ni = 1'b1;
    cyc(1);
    total++;
    if (imemReq_o !== 1'b1 || imemAddr_o !== RESET_PC) begin
      bad++;
      $display("FAIL restart got=%b/%h want=1/%h",
               imemReq_o, imemAddr_o, RESET_PC);
    end
    p0 = pops;
    cyc(8);
    total++;
    if (pops - p0 < 6) begin
      bad++; $display("FAIL restart_run got=%0d want>=6", pops - p0);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_ack_delay();
    test_redirect_flush();
    test_redirect_drop();
    test_wrap();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

endmodule
